operand_fifo: RTL
=================

// Module: operand_fifo
// PURPOSE
//  Synchronous input FIFO directly upstream of control_path.
//  - Buffers w-bit operand/opcode words from the external producer (valid/ready_wr).
//  - Presents them to control_path on fifo_out, one word per read strobe.
//  - Decouples the producer from ALU/divider stalls (ready_alu low during multi-cycle ops).
// PARAMETERS
//  w      8  data word width, matches control_path w
//  DEPTH  8  number of entries; power of two, >= 2
//  AW     $clog2(DEPTH)  pointer width; derived, never overridden
// PORTS
//  clk         in   1      single clock, rising-edge
//  rst         in   1      synchronous, active-high reset
//  in          in   w      write data from producer
//  valid       in   1      producer write request
//  ready_wr    out  1      FIFO can accept a word (= !full)
//  rd          in   1      read strobe from control_path
//  valid_rd    out  1      word available (= !empty)
//  fifo_out    out  w      registered read data
//  out_vld     out  1      1-cycle pulse: fifo_out updated this cycle
//  count       out  AW+1   current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, fifo_out=0, out_vld=0.
//    ready_wr=1, valid_rd=0. Memory contents are not cleared.
//  - Reset mid-operation discards all stored words; no read/write is performed that cycle.
//  - Write: valid && ready_wr at posedge -> mem[wr_ptr]<=in, wr_ptr++.
//  - valid && !ready_wr -> word dropped, no state change.
//    The producer must hold valid until ready_wr.
//  - Read: rd && valid_rd at posedge -> fifo_out<=mem[rd_ptr], rd_ptr++, out_vld<=1 next cycle.
//    Latency: 1 clk from accepted rd to fifo_out/out_vld.
//  - rd && !valid_rd -> ignored; fifo_out holds, out_vld=0.
//  - fifo_out holds its last value whenever no read is accepted.
//  - Pointers are AW bits and wrap DEPTH-1 -> 0. count tracks occupancy.
//    full  = (count==DEPTH).
//    empty = (count==0).
//  - Simultaneous accepted write and read: both occur, count unchanged.
//  - Write when full is rejected even if rd is asserted the same cycle (no pass-through).
//    ready_wr reasserts the cycle after the read.
//  - Write when empty with rd asserted: write accepted, read ignored.
//    valid_rd rises next cycle (no bypass).
//  - ready_wr, valid_rd and count are registered-state derived; no combinational path from inputs.
// CONFIGURATION
//  OPERAND_FIFO_ERR_EN defined:
//   - adds outputs overflow_err (1) and underflow_err (1).
//   - overflow_err  sets sticky on valid && !ready_wr.
//   - underflow_err sets sticky on rd && !valid_rd.
//   - Both errors clear only on rst (reset value 0) and are set on the cycle after the offending edge.
//  OPERAND_FIFO_ERR_EN undefined:
//   - ports absent; such requests are silently ignored as described above.
// TESTING
//  1. Reset, then 3 writes (0x11,0x22,0x33) -> count=3, valid_rd=1;
//     3 rd -> fifo_out 0x11,0x22,0x33 each 1 clk after rd with out_vld pulses; count=0.
//  2. Fill DEPTH=8 words 0x00..0x07 -> ready_wr=0 after 8th write;
//     9th write 0xFF dropped; drain -> 0x00..0x07, no 0xFF.
//  3. Wrap: write 6, read 6, write 8 (0xA0..0xA7), read 8 -> data in order across wrap; count back to 0.
//  4. Half-full (count=4), valid=rd=1 for 10 clks -> count stays 4, output order preserved.
//     Full with valid=rd=1 -> read accepted, write rejected, count=7.
//  5. count=5, assert rst with valid=rd=1 -> next cycle count=0, valid_rd=0, fifo_out=0, out_vld=0.
//  6. ERR_EN: rd when empty -> underflow_err=1;
//     write when full -> overflow_err=1; both persist until rst.

Source files
------------

// File: rtl/operand_fifo.sv
// operand_fifo: synchronous operand/opcode FIFO feeding control_path.
// Optional sticky overflow/underflow flags when OPERAND_FIFO_ERR_EN is defined.
module operand_fifo #(
    parameter int w     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [w-1:0]  in,
    input  logic          valid,
    output logic          ready_wr,
    input  logic          rd,
    output logic          valid_rd,
    output logic [w-1:0]  fifo_out,
    output logic          out_vld,
    output logic [AW:0]   count
`ifdef OPERAND_FIFO_ERR_EN
    ,
    output logic          overflow_err,
    output logic          underflow_err
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [w-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;

    // Flags come only from registered occupancy, never from inputs.
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign ready_wr = !full;
    assign valid_rd = !empty;
    assign count    = count_q;

    // Accepted transfers; a full FIFO never passes a write through a read.
    assign wr_en = valid && !full && !rst;
    assign rd_en = rd && !empty && !rst;

    // Occupancy change for this cycle.
    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Registered read port with one-cycle update pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_out <= '0;
            out_vld  <= 1'b0;
        end else begin
            out_vld <= rd_en;
            if (rd_en) begin
                fifo_out <= mem[rd_ptr];
            end
        end
    end

`ifdef OPERAND_FIFO_ERR_EN
    // Sticky protocol-violation flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (valid && full) begin
                overflow_err <= 1'b1;
            end
            if (rd && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end
`endif

endmodule
